// File: rtl/qif_neuron_scheduler.sv
// Time-multiplexed QIF membrane update over N_NEURONS neurons, one sweep per tick.
// Optional refractory hold per neuron: define QIF_SCHED_REFRACTORY_EN.
module qif_neuron_scheduler #(
    parameter int                N_NEURONS     = 4,
    parameter logic signed [7:0] V_RESET       = -8'sd20,
    parameter logic signed [7:0] V_PEAK        = 8'sd50,
    parameter int                REFRAC_SWEEPS = 2
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           tick,
    input  logic [8*N_NEURONS-1:0]         b_vec,
    input  logic [$clog2(N_NEURONS)-1:0]   rd_idx,
    output logic signed [7:0]              rd_v,
    output logic [N_NEURONS-1:0]           spike_vec,
    output logic                           done,
    output logic                           busy,
    output logic                           overrun
);

    localparam int IDX_W = $clog2(N_NEURONS);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N_NEURONS - 1);

    if (N_NEURONS < 2 || N_NEURONS > 16 || REFRAC_SWEEPS < 1) begin : g_bad_param
        $error("qif_neuron_scheduler: parameter out of range");
    end

    typedef enum logic [2:0] {S_IDLE, S_FETCH, S_CALC, S_WB, S_DONE} state_t;

    state_t                state, state_nxt;
    logic [IDX_W-1:0]      idx;
    logic signed [7:0]     v_mem [N_NEURONS];
    logic signed [7:0]     b_lat [N_NEURONS];
    logic signed [7:0]     v_r, b_r, nxt_r;
    logic [N_NEURONS-1:0]  spike_acc;

    logic signed [7:0]     q, bq, calc_next;
    logic signed [15:0]    q16, bq16, v16, sum16;
    logic                  spike_now, hold_now;

    // State register; the reset input is active-high despite its name.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) state <= S_IDLE;
        else       state <= state_nxt;
    end

    always_comb begin
        // NOTE: default first so every path assigns state_nxt and no latch is inferred.
        state_nxt = state;
        case (state)
            S_IDLE:  if (tick) state_nxt = S_FETCH;
            S_FETCH: state_nxt = S_CALC;
            S_CALC:  state_nxt = S_WB;
            S_WB:    state_nxt = (idx == LAST_IDX) ? S_DONE : S_FETCH;
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    always_comb begin
        busy = (state != S_IDLE);
        done = (state == S_DONE);
    end

    // q*q*bq never exceeds 8192 in magnitude, so 16 bits hold V plus the increment.
    always_comb begin
        q     = v_r / 8'sd8;
        bq    = b_r / 8'sd4;
        q16   = {{8{q[7]}}, q};
        bq16  = {{8{bq[7]}}, bq};
        v16   = {{8{v_r[7]}}, v_r};
        sum16 = v16 + q16 * q16 * bq16;
        spike_now = (v_r >= V_PEAK) && !hold_now;
        if (hold_now || spike_now) calc_next = V_RESET;
        else if (sum16 > 16'sd127) calc_next = 8'sd127;
        else if (sum16 < -16'sd128) calc_next = -8'sd128;
        else calc_next = sum16[7:0];
    end

`ifdef QIF_SCHED_REFRACTORY_EN
    localparam int RW = $clog2(REFRAC_SWEEPS + 1);
    logic [RW-1:0] refrac [N_NEURONS];
    logic          hold_r;

    assign hold_now = (refrac[idx] != '0);

    // Counter loads on the spike sweep and only counts down on later held sweeps.
    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            hold_r <= 1'b0;
            for (int i = 0; i < N_NEURONS; i++) refrac[i] <= '0;
        end else begin
            if (state == S_CALC) begin
                hold_r <= hold_now;
                if (spike_now) refrac[idx] <= RW'(REFRAC_SWEEPS);
            end
            if (state == S_WB && hold_r) refrac[idx] <= refrac[idx] - 1'b1;
        end
    end
`else
    assign hold_now = 1'b0;
`endif

    always_ff @(posedge clk or posedge rst_n) begin
        if (rst_n) begin
            idx       <= '0;
            v_r       <= V_RESET;
            b_r       <= '0;
            nxt_r     <= V_RESET;
            spike_acc <= '0;
            spike_vec <= '0;
            overrun   <= 1'b0;
            rd_v      <= V_RESET;
            // NOTE: the state array is small and must come up at V_RESET, so it is
            // reset like ordinary flops rather than left as an uninitialised RAM.
            for (int i = 0; i < N_NEURONS; i++) begin
                v_mem[i] <= V_RESET;
                b_lat[i] <= '0;
            end
        end else begin
            // NOTE: non-blocking throughout, so every branch sees pre-edge values.
            if (tick && state != S_IDLE) overrun <= 1'b1;
            case (state)
                S_IDLE: if (tick) begin
                    for (int i = 0; i < N_NEURONS; i++) b_lat[i] <= b_vec[8*i +: 8];
                    spike_acc <= '0;
                    idx       <= '0;
                end
                S_FETCH: begin
                    v_r <= v_mem[idx];
                    b_r <= b_lat[idx];
                end
                S_CALC: begin
                    nxt_r <= calc_next;
                    if (spike_now) spike_acc[idx] <= 1'b1;
                end
                S_WB: begin
                    v_mem[idx] <= nxt_r;
                    if (idx != LAST_IDX) idx <= idx + 1'b1;
                end
                S_DONE: spike_vec <= spike_acc;
                default: ;
            endcase
            rd_v <= (32'(rd_idx) < N_NEURONS) ? v_mem[rd_idx] : 8'sd0;
        end
    end

endmodule
